pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 226 ++++++++++++++++++++++
 tb/tb_pwm_capture.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures the period and duty of an asynchronous PWM input.
//
// A 2-FF synchronizer produces pwm_s; rising edges of pwm_s restart the period
// and high-time counters. Each captured period (rise to rise, while idle in
// MEASURE) is divided by a 9-step restoring divider into an 8-bit duty value.
// A static input is reported after TIMEOUT cycles without a rising edge.
//
// Optional feature: define PWM_CAPTURE_GLITCH_FILTER_EN to require the
// synchronized input to hold a new level for 3 consecutive cycles before
// pwm_s follows it (2 extra cycles of latency, rejects pulses <= 2 cycles).
//
// Ports:
//   clock_in    sole clock, all state on posedge
//   reset_in    asynchronous active-high reset
//   pwm_in      PWM waveform, asynchronous to clock_in
//   value_out   measured duty, 0 = 0%, 255 = 100%
//   valid_out   one-cycle pulse on each value_out/period_out update
//   period_out  last measured period in cycles, 0 after a timeout report

module pwm_capture #(
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned TIMEOUT     = 16'hFFFF
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   pwm_in,
  output logic [7:0]             value_out,
  output logic                   valid_out,
  output logic [COUNT_WIDTH-1:0] period_out
);

  localparam int unsigned CW = COUNT_WIDTH;
  localparam int unsigned RW = COUNT_WIDTH + 1;  // remainder needs one spare bit after the shift
  localparam int unsigned QW = 9;                 // quotient up to 256
  localparam int unsigned IW = 4;
  localparam logic [IW-1:0] LAST_ITER   = IW'(QW);
  localparam logic [CW-1:0] CNT_MAX     = '1;
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic sync1;
  logic sync2;
  logic pwm_s;
  logic pwm_s_prev;
  logic rise;
  logic timeout;

  logic [CW-1:0] period_cnt;
  logic [CW-1:0] high_cnt;

  logic [CW-1:0] div_p;
  logic [RW-1:0] rem;
  logic [QW-1:0] quo;
  logic [IW-1:0] iter;
  logic [RW-1:0] p_ext;
  logic          ge;
  logic [RW-1:0] rem_sub;

  logic latch_en;
  logic div_step;
  logic write_meas;
  logic write_tmo;

  // Two-flop synchronizer for the asynchronous PWM input
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic hist1;
  logic hist2;

  // Last two synchronized samples; pwm_s moves only when three samples agree
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      hist1 <= 1'b0;
      hist2 <= 1'b0;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
    end
  end

  // pwm_s_prev doubles as the held filter output
  assign pwm_s = ((sync2 == hist1) && (hist1 == hist2)) ? sync2 : pwm_s_prev;
`else
  assign pwm_s = sync2;
`endif

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      pwm_s_prev <= 1'b0;
    end else begin
      pwm_s_prev <= pwm_s;
    end
  end

  assign rise    = pwm_s & ~pwm_s_prev;
  // A rise in the same cycle suppresses the timeout report
  assign timeout = ~rise & (period_cnt == TIMEOUT_CNT);

  // Period and high-time counters, restarted by every rise, saturating
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= CW'(1);
      high_cnt   <= CW'(1);
    end else begin
      if (timeout) begin
        period_cnt <= CW'(1);
      end else if (period_cnt != CNT_MAX) begin
        period_cnt <= period_cnt + CW'(1);
      end
      if (pwm_s && (high_cnt != CNT_MAX)) begin
        high_cnt <= high_cnt + CW'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and datapath controls; timeout overrides any state
  always_comb begin
    state_nxt  = state;
    latch_en   = 1'b0;
    div_step   = 1'b0;
    write_meas = 1'b0;
    write_tmo  = 1'b0;
    if (timeout) begin
      write_tmo = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            latch_en  = 1'b1;
            state_nxt = DIVIDE;
          end
        end
        DIVIDE: begin
          // Rises here only restart the counters; they are not captured
          if (iter == LAST_ITER) begin
            write_meas = 1'b1;
            state_nxt  = MEASURE;
          end else begin
            div_step = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Restoring divider: Q = floor(H*256/P). Since H <= P the remainder starts
  // at H and each step compares, subtracts, then shifts for the next bit.
  assign p_ext   = RW'(div_p);
  assign ge      = (rem >= p_ext);
  assign rem_sub = ge ? (rem - p_ext) : rem;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      div_p <= '0;
      rem   <= '0;
      quo   <= '0;
      iter  <= '0;
    end else if (latch_en) begin
      div_p <= period_cnt;
      rem   <= RW'(high_cnt);
      quo   <= '0;
      iter  <= '0;
    end else if (div_step) begin
      rem   <= {rem_sub[RW-2:0], 1'b0};
      quo   <= {quo[QW-2:0], ge};
      iter  <= iter + IW'(1);
    end
  end

  // Registered result outputs
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      value_out  <= '0;
      valid_out  <= 1'b0;
      period_out <= '0;
    end else begin
      valid_out <= write_meas | write_tmo;
      if (write_tmo) begin
        value_out  <= pwm_s ? 8'hFF : 8'h00;
        period_out <= '0;
      end else if (write_meas) begin
        value_out  <= quo[QW-1] ? 8'hFF : quo[7:0];
        period_out <= div_p;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed stimulus for pwm_capture, checked
// cycle by cycle against an event-level reference of the capture rules.

module tb_pwm_capture;

  localparam int unsigned CW  = 16;
  localparam int          TMO = 1500;

  logic          clock_in = 1'b0;
  logic          reset_in;
  logic          pwm_in;
  logic [7:0]    value_out;
  logic          valid_out;
  logic [CW-1:0] period_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state
  bit m_s1, m_s2, m_prev;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  bit m_d1, m_d2;
`endif
  bit m_armed;
  int m_cnt, m_h, m_pend_edge, m_pend_val, m_pend_per;
  bit exp_valid;
  int exp_value, exp_period;

  // Observation helpers for directed checks
  int n_valid, last_val, last_per, min_per;

  always #5 clock_in = ~clock_in;

  pwm_capture #(
    .COUNT_WIDTH(CW),
    .TIMEOUT    (TMO)
  ) dut (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .pwm_in    (pwm_in),
    .value_out (value_out),
    .valid_out (valid_out),
    .period_out(period_out)
  );

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_prev = 0;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    m_d1 = 0; m_d2 = 0;
`endif
    m_armed = 0; m_cnt = 0; m_h = 0;
    m_pend_edge = -1; m_pend_val = 0; m_pend_per = 0;
    exp_valid = 0; exp_value = 0; exp_period = 0;
  endtask

  // One clock edge of the reference: rise/timeout rules, capture when
  // armed and not busy, result due 10 edges after the capture edge.
  task automatic model_step();
    bit s, rise, tmo;
    int q;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    s = (m_s2 == m_d1 && m_d1 == m_d2) ? m_s2 : m_prev;
`else
    s = m_s2;
`endif
    rise = s && !m_prev;
    tmo  = !rise && (m_cnt == TMO);
    exp_valid = 0;
    if (rise) begin
      if (!m_armed) begin
        m_armed = 1;
      end else if (m_pend_edge < 0) begin
        q = (m_h * 256) / m_cnt;
        m_pend_val  = (q > 255) ? 255 : q;
        m_pend_per  = m_cnt;
        m_pend_edge = cyc + 10;
      end
      m_cnt = 1;
      m_h   = 1;
    end else begin
      if (tmo) begin
        exp_valid   = 1;
        exp_value   = s ? 255 : 0;
        exp_period  = 0;
        m_armed     = 0;
        m_pend_edge = -1;
        m_cnt       = 1;
      end else begin
        m_cnt++;
      end
      if (s) m_h++;
    end
    if (m_pend_edge == cyc) begin
      exp_valid   = 1;
      exp_value   = m_pend_val;
      exp_period  = m_pend_per;
      m_pend_edge = -1;
    end
    m_prev = s;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    m_d2 = m_d1;
    m_d1 = m_s2;
`endif
    m_s2 = m_s1;
    m_s1 = pwm_in;
  endtask

  // One cycle: step reference at the edge, compare 1 time unit later, drive next input
  task automatic tick(input bit v);
    @(posedge clock_in);
    if (!reset_in) model_step();
    #1;
    check("valid", int'(valid_out), int'(exp_valid));
    check("value", int'(value_out), exp_value);
    check("period", int'(period_out), exp_period);
    if (valid_out) begin
      n_valid++;
      last_val = int'(value_out);
      last_per = int'(period_out);
      if (int'(period_out) < min_per) min_per = int'(period_out);
    end
    pwm_in = v;
    cyc++;
  endtask

  task automatic apply_reset(input int n);
    reset_in = 1'b1;
    #1;
    model_reset();
    check("rst_valid", int'(valid_out), 0);
    check("rst_value", int'(value_out), 0);
    check("rst_period", int'(period_out), 0);
    repeat (n) tick(1'b0);
    reset_in = 1'b0;
  endtask

  task automatic run_pwm(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < per; i++) tick(i < hi);
  endtask

  task automatic run_static(input bit v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  initial begin
    int per, hi, guard;
    reset_in = 1'b1;
    pwm_in   = 1'b0;
    model_reset();
    n_valid = 0; last_val = 0; last_per = 0; min_per = 1 << 30;
    repeat (3) tick(1'b0);
    check("init_value", int'(value_out), 0);
    check("init_valid", int'(valid_out), 0);
    reset_in = 1'b0;
    run_static(1'b0, 5);

    // 1280/320: four captures of 64 / 1280
    apply_reset(2);
    n_valid = 0;
    run_pwm(1280, 320, 5);
    check("p1280_count", n_valid, 4);
    check("p1280_value", last_val, 64);
    check("p1280_period", last_per, 1280);

    // One low cycle per 100 -> 253
    run_pwm(100, 99, 4);
    check("p100_value", last_val, 253);
    check("p100_period", last_per, 100);

    // Near-full duty reaches 255
    run_pwm(300, 299, 3);
    check("p300_value", last_val, 255);

    // Random periods and duties
    for (int k = 0; k < 40; k++) begin
      per = int'($urandom_range(12, 300));
      hi  = int'($urandom_range(1, per - 1));
      run_pwm(per, hi, 1);
    end

    // Static high: repeated timeout reports of 255 / 0
    run_static(1'b1, 20);
    n_valid = 0;
    run_static(1'b1, 3 * TMO + 80);
    check("static_hi_count", n_valid, 3);
    check("static_hi_value", last_val, 255);
    check("static_hi_period", last_per, 0);

    // Static low: reports of 0
    n_valid = 0;
    run_static(1'b0, 3 * TMO + 100);
    check("static_lo_value", last_val, 0);
    check("static_lo_period", last_per, 0);

    // Period 8: every other period captured while the divider is busy
    n_valid = 0;
    run_pwm(8, 4, 25);
    check("p8_count", n_valid, 12);
    check("p8_value", last_val, 128);
    check("p8_period", last_per, 8);

    // Short random periods around the busy window
    for (int k = 0; k < 30; k++) begin
      per = int'($urandom_range(8, 20));
      hi  = int'($urandom_range(1, per - 1));
      run_pwm(per, hi, 1);
    end

    // Reset 4 cycles after a capture, then two rises needed for a result
    apply_reset(2);
    guard = 0;
    while (m_pend_edge < 0 && guard < 2000) begin
      tick((guard % 200) < 60);
      guard++;
    end
    check("latch_seen", int'(m_pend_edge >= 0), 1);
    for (int i = 0; i < 4; i++) tick(((guard + i) % 200) < 60);
    apply_reset(3);
    n_valid = 0;
    run_pwm(200, 60, 1);
    check("rst_no_valid", n_valid, 0);
    run_pwm(200, 60, 1);
    check("rst_one_valid", n_valid, 1);
    check("rst_value_after", last_val, 76);

    // 2-cycle low glitch inside the high phase
    apply_reset(2);
    min_per = 1 << 30;
    for (int k = 0; k < 6; k++) begin
      run_static(1'b1, 30);
      run_static(1'b0, 2);
      run_static(1'b1, 28);
      run_static(1'b0, 140);
    end
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    check("glitch_value", last_val, 76);
    check("glitch_period", min_per, 200);
`else
    check("glitch_short", min_per, 32);
`endif

    run_static(1'b0, 20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
